// File: rtl/sysmem_pkg.sv
// Shared types and lane geometry for the system-memory bridge.
package sysmem_pkg;
    localparam int NUM_LANES = 4;
    localparam int LANE_W    = 8;
    localparam int BUS_W     = NUM_LANES * LANE_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        ACK  = 2'd2,
        LD   = 2'd3
    } state_t;
endpackage

// File: rtl/sysmem_if.sv
// PicoRV32 native memory bus: the CPU is master, the memory bridge is slave.
interface sysmem_if;
    import sysmem_pkg::*;

    logic                 mem_valid;
    logic [31:0]          mem_addr;
    logic [BUS_W-1:0]     mem_wdata;
    logic [NUM_LANES-1:0] mem_wstrb;
    logic                 mem_ready;
    logic [BUS_W-1:0]     mem_rdata;

    modport master (
        output mem_valid, mem_addr, mem_wdata, mem_wstrb,
        input  mem_ready, mem_rdata
    );

    modport slave (
        input  mem_valid, mem_addr, mem_wdata, mem_wstrb,
        output mem_ready, mem_rdata
    );
endinterface

// File: rtl/sysmem_loader.sv
// Boot-loader byte counter: ld_en edge detect, running byte index, wrap flag
// and the one-hot lane select for the byte currently being written.
module sysmem_loader
    import sysmem_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic                 clka,
    input  logic                 rsta,
    input  logic                 ld_en,
    input  logic                 ld_acc,
    output logic [ADDR_W+1:0]    ld_count,
    output logic                 ld_wrap,
    output logic [ADDR_W+1:0]    ld_idx,
    output logic [NUM_LANES-1:0] ld_onehot
);
    localparam logic [ADDR_W+1:0] ONE = 1;

    logic ld_en_q;
    logic ld_rise;
    logic wrap_eff;

    // A byte arriving in the rising cycle already lands at index 0.
    assign ld_rise  = ld_en & ~ld_en_q;
    assign ld_idx   = ld_rise ? '0 : ld_count;
    assign wrap_eff = ld_rise ? 1'b0 : ld_wrap;

    always_comb begin
        ld_onehot = '0;
        ld_onehot[ld_idx[1:0]] = 1'b1;
    end

    always_ff @(posedge clka or posedge rsta) begin
        if (rsta) begin
            ld_en_q  <= 1'b0;
            ld_count <= '0;
            ld_wrap  <= 1'b0;
        end else begin
            ld_en_q <= ld_en;
            if (ld_acc) begin
                ld_count <= ld_idx + ONE;
                ld_wrap  <= wrap_eff | (&ld_idx);
            end else if (ld_rise) begin
                ld_count <= '0;
                ld_wrap  <= 1'b0;
            end
        end
    end
endmodule

// File: rtl/sysmem_ctrl.sv
// Bridge from the PicoRV32 memory bus to four byte-lane BRAMs, with a
// sequential byte-stream loader that owns the lanes while ld_en is high.
module sysmem_ctrl
    import sysmem_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          ADDR_W    = 10
) (
    input  logic                                clka,
    input  logic                                rsta,
    sysmem_if.slave                             bus,
    input  logic                                ld_en,
    input  logic                                ld_valid,
    input  logic [LANE_W-1:0]                   ld_data,
    output logic                                ld_ready,
    output logic [ADDR_W+1:0]                   ld_count,
    output logic                                ld_wrap,
    output logic [ADDR_W-1:0]                   lane_addr,
    output logic [NUM_LANES-1:0]                lane_ce,
    output logic [NUM_LANES-1:0]                lane_we,
    output logic [NUM_LANES-1:0][LANE_W-1:0]    lane_di,
    input  logic [NUM_LANES-1:0][LANE_W-1:0]    lane_do
);
    state_t                 state;
    logic                   hit;
    logic                   idle;
    logic                   cpu_acc;
    logic                   ld_acc;
    logic                   is_wr;
    logic [ADDR_W+1:0]      ld_idx;
    logic [NUM_LANES-1:0]   ld_onehot;

    assign hit   = (bus.mem_addr[31:ADDR_W+2] == BASE_ADDR[31:ADDR_W+2]);
    assign idle  = (state == IDLE);
    assign is_wr = |bus.mem_wstrb;

    // Accepts are gated by reset so the lane strobes drop the moment rsta rises.
    assign ld_acc  = ~rsta & idle & ld_en & ld_valid;
    assign cpu_acc = ~rsta & idle & bus.mem_valid & hit & ~ld_en & ~bus.mem_ready;

    assign ld_ready  = ld_acc;
    assign lane_addr = ld_acc ? ld_idx[ADDR_W+1:2] : bus.mem_addr[ADDR_W+1:2];

    sysmem_loader #(.ADDR_W(ADDR_W)) u_loader (
        .clka      (clka),
        .rsta      (rsta),
        .ld_en     (ld_en),
        .ld_acc    (ld_acc),
        .ld_count  (ld_count),
        .ld_wrap   (ld_wrap),
        .ld_idx    (ld_idx),
        .ld_onehot (ld_onehot)
    );

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        assign lane_ce[i] = cpu_acc ? (~is_wr | bus.mem_wstrb[i]) : (ld_acc & ld_onehot[i]);
        assign lane_we[i] = cpu_acc ? bus.mem_wstrb[i] : (ld_acc & ld_onehot[i]);
        assign lane_di[i] = ld_en ? ld_data : bus.mem_wdata[i*LANE_W +: LANE_W];
    end

    // Writes acknowledge straight away; reads wait one cycle for the NOREG doa.
    always_ff @(posedge clka or posedge rsta) begin
        if (rsta) begin
            state         <= IDLE;
            bus.mem_ready <= 1'b0;
            bus.mem_rdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cpu_acc) begin
                        if (is_wr) begin
                            state         <= ACK;
                            bus.mem_ready <= 1'b1;
                        end else begin
                            state <= RD;
                        end
                    end
                end
                RD: begin
                    bus.mem_rdata <= lane_do;
                    bus.mem_ready <= 1'b1;
                    state         <= ACK;
                end
                ACK: begin
                    bus.mem_ready <= 1'b0;
                    state         <= IDLE;
                end
                default: begin
                    bus.mem_ready <= 1'b0;
                    state         <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_sysmem_ctrl.sv
// Bench for sysmem_ctrl: directed scenarios plus randomized traffic, checked
// every cycle against a byte-image model of the window and the loader.
module tb_sysmem_ctrl;
    localparam int AW = 10;
    localparam int NB = 4 * (1 << AW);

    logic clka = 1'b0;
    logic rsta = 1'b1;
    always #5 clka = ~clka;

    sysmem_if bus();

    logic          ld_en = 1'b0, ld_valid = 1'b0, ld_ready, ld_wrap;
    logic [7:0]    ld_data = 8'h00;
    logic [AW+1:0] ld_count;
    logic [AW-1:0] lane_addr;
    logic [3:0]    lane_ce, lane_we;
    logic [31:0]   lane_di;
    logic [31:0]   lane_do = 32'h0;

    sysmem_ctrl #(.BASE_ADDR(32'h0000_0000), .ADDR_W(AW)) dut (
        .clka(clka), .rsta(rsta), .bus(bus),
        .ld_en(ld_en), .ld_valid(ld_valid), .ld_data(ld_data), .ld_ready(ld_ready),
        .ld_count(ld_count), .ld_wrap(ld_wrap),
        .lane_addr(lane_addr), .lane_ce(lane_ce), .lane_we(lane_we),
        .lane_di(lane_di), .lane_do(lane_do)
    );

    // Four NOREG byte-lane BRAMs.
    logic [7:0] bram [4][1024];
    initial for (int i = 0; i < 4; i++) for (int j = 0; j < 1024; j++) bram[i][j] = 8'h00;
    always @(posedge clka) begin
        for (int i = 0; i < 4; i++) begin
            if (lane_ce[i]) begin
                if (lane_we[i]) bram[i][lane_addr] <= lane_di[i*8 +: 8];
                else            lane_do[i*8 +: 8] <= bram[i][lane_addr];
            end
        end
    end

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, got, exp);
        end
    endtask

    // Reference model: byte image of the window, cycles left in the CPU
    // transaction, and the loader's byte index.
    logic [7:0]  ref_mem [NB];
    int          busy = 0;
    logic        exp_ready = 1'b0;
    logic [31:0] exp_rdata = 32'h0;
    logic [31:0] pend = 32'h0;
    int          m_cnt = 0;
    bit          m_wrap = 1'b0;
    bit          prev_en = 1'b0;
    initial for (int j = 0; j < NB; j++) ref_mem[j] = 8'h00;

    function automatic bit in_window(input logic [31:0] a);
        return a < NB;
    endfunction
    function automatic bit cpu_go();
        return !rsta && busy == 0 && bus.mem_valid && in_window(bus.mem_addr) && !ld_en;
    endfunction
    function automatic bit ld_go();
        return !rsta && busy == 0 && ld_en && ld_valid;
    endfunction
    function automatic int eff_idx();
        return (ld_en && !prev_en) ? 0 : m_cnt;
    endfunction

    task automatic model_step();
        bit c, l, rise;
        int e, w;
        if (rsta) begin
            busy = 0; exp_ready = 1'b0; exp_rdata = 32'h0;
            m_cnt = 0; m_wrap = 1'b0; prev_en = 1'b0;
            return;
        end
        c = cpu_go(); l = ld_go(); e = eff_idx(); rise = ld_en && !prev_en;
        if (busy == 2) begin busy = 1; exp_ready = 1'b1; exp_rdata = pend; end
        else if (busy == 1) begin busy = 0; exp_ready = 1'b0; end
        if (c) begin
            w = int'(bus.mem_addr[AW+1:2]);
            if (bus.mem_wstrb != 4'h0) begin
                for (int i = 0; i < 4; i++)
                    if (bus.mem_wstrb[i]) ref_mem[w*4+i] = bus.mem_wdata[i*8 +: 8];
                busy = 1; exp_ready = 1'b1;
            end else begin
                pend = {ref_mem[w*4+3], ref_mem[w*4+2], ref_mem[w*4+1], ref_mem[w*4]};
                busy = 2;
            end
        end
        if (l) begin
            ref_mem[e] = ld_data;
            m_wrap = (rise ? 1'b0 : m_wrap) || (e == NB - 1);
            m_cnt = (e + 1) % NB;
        end else if (rise) begin
            m_cnt = 0; m_wrap = 1'b0;
        end
        prev_en = ld_en;
    endtask

    initial forever begin
        @(posedge clka or posedge rsta);
        model_step();
    end

    // Per-cycle comparison, away from the active edge.
    initial forever begin
        bit c, l;
        int e;
        logic [3:0] ece, ewe;
        @(negedge clka);
        c = cpu_go(); l = ld_go(); e = eff_idx();
        ece = 4'h0; ewe = 4'h0;
        if (c) begin
            ece = (bus.mem_wstrb != 4'h0) ? bus.mem_wstrb : 4'hF;
            ewe = bus.mem_wstrb;
        end else if (l) begin
            ece = 4'h1 << (e % 4);
            ewe = ece;
        end
        check("lane_ce", {28'h0, lane_ce}, {28'h0, ece});
        check("lane_we", {28'h0, lane_we}, {28'h0, ewe});
        check("ld_ready", {31'h0, ld_ready}, {31'h0, l});
        if (c) check("lane_addr_cpu", {22'h0, lane_addr}, {22'h0, bus.mem_addr[AW+1:2]});
        if (c && bus.mem_wstrb != 4'h0) check("lane_di_cpu", lane_di, bus.mem_wdata);
        if (l) begin
            check("lane_addr_ld", {22'h0, lane_addr}, 32'(e / 4));
            check("lane_di_ld", lane_di, {4{ld_data}});
        end
        check("mem_ready", {31'h0, bus.mem_ready}, {31'h0, exp_ready});
        check("mem_rdata", bus.mem_rdata, exp_rdata);
        check("ld_count", {20'h0, ld_count}, 32'(m_cnt));
        check("ld_wrap", {31'h0, ld_wrap}, {31'h0, m_wrap});
    end

    task automatic tick();
        @(posedge clka);
        #1;
    endtask

    task automatic cpu(input logic v, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        bus.mem_valid = v; bus.mem_addr = a; bus.mem_wdata = d; bus.mem_wstrb = s;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

    logic [7:0] boot [5];

    initial begin
        boot[0] = 8'h13; boot[1] = 8'h00; boot[2] = 8'h00; boot[3] = 8'h00; boot[4] = 8'h6F;
        cpu(1'b0, 32'h0, 32'h0, 4'h0);
        rsta = 1'b1;
        repeat (3) tick();
        check("reset_ready", {31'h0, bus.mem_ready}, 32'h0);
        check("reset_count", {20'h0, ld_count}, 32'h0);
        rsta = 1'b0;
        tick();

        // Full-word write
        cpu(1'b1, 32'h10, 32'h1122_3344, 4'hF);
        #3;
        check("wr_lane_addr", {22'h0, lane_addr}, 32'd4);
        check("wr_lane_we", {28'h0, lane_we}, 32'hF);
        check("wr_ready_early", {31'h0, bus.mem_ready}, 32'h0);
        tick();
        check("wr_ready", {31'h0, bus.mem_ready}, 32'h1);
        bus.mem_valid = 1'b0;
        tick();
        check("wr_ready_pulse", {31'h0, bus.mem_ready}, 32'h0);

        // Byte write then read back
        cpu(1'b1, 32'h10, 32'h0000_AA00, 4'h2);
        #3;
        check("bw_lane_we", {28'h0, lane_we}, 32'h2);
        check("bw_lane_ce", {28'h0, lane_ce}, 32'h2);
        tick(); bus.mem_valid = 1'b0; tick();
        cpu(1'b1, 32'h10, 32'h0, 4'h0);
        #3;
        check("rd_lane_ce", {28'h0, lane_ce}, 32'hF);
        check("rd_lane_we", {28'h0, lane_we}, 32'h0);
        tick();
        check("rd_ready_rd", {31'h0, bus.mem_ready}, 32'h0);
        tick();
        check("rd_ready", {31'h0, bus.mem_ready}, 32'h1);
        check("rd_data", bus.mem_rdata, 32'h1122_AA44);
        bus.mem_valid = 1'b0;
        tick();
        check("rd_ready_pulse", {31'h0, bus.mem_ready}, 32'h0);

        // Out-of-window read never acknowledged
        cpu(1'b1, 32'h1000, 32'h0, 4'h0);
        for (int k = 0; k < 8; k++) begin
            #3;
            check("oow_ce", {28'h0, lane_ce}, 32'h0);
            check("oow_ready", {31'h0, bus.mem_ready}, 32'h0);
            tick();
        end
        bus.mem_valid = 1'b0;

        // Boot loader: five bytes then a CPU read of word 0
        ld_en = 1'b1;
        tick();
        for (int k = 0; k < 5; k++) begin
            ld_valid = 1'b1; ld_data = boot[k];
            #3;
            check("ld_ready_stream", {31'h0, ld_ready}, 32'h1);
            tick();
        end
        ld_valid = 1'b0;
        check("ld_count5", {20'h0, ld_count}, 32'd5);
        ld_en = 1'b0;
        tick();
        cpu(1'b1, 32'h0, 32'h0, 4'h0);
        tick(); tick();
        check("boot_ready", {31'h0, bus.mem_ready}, 32'h1);
        check("boot_word0", bus.mem_rdata, 32'h0000_0013);
        bus.mem_valid = 1'b0;
        tick();

        // Full-window stream wraps the counter
        ld_en = 1'b1;
        tick();
        ld_valid = 1'b1;
        for (int k = 0; k < NB; k++) begin
            ld_data = 8'($urandom);
            if (k == NB - 1) begin
                check("wrap_pre_count", {20'h0, ld_count}, 32'(NB - 1));
                check("wrap_pre_flag", {31'h0, ld_wrap}, 32'h0);
            end
            tick();
        end
        ld_valid = 1'b0;
        check("wrap_count", {20'h0, ld_count}, 32'h0);
        check("wrap_flag", {31'h0, ld_wrap}, 32'h1);
        ld_en = 1'b0;
        tick();

        // ld_en rising while a read sits in RD
        cpu(1'b1, 32'h4, 32'h0, 4'h0);
        tick();
        ld_en = 1'b1; ld_valid = 1'b1; ld_data = 8'hA5;
        #3;
        check("rdld_ready_rd", {31'h0, ld_ready}, 32'h0);
        tick();
        check("rdld_mem_ready", {31'h0, bus.mem_ready}, 32'h1);
        check("rdld_ready_ack", {31'h0, ld_ready}, 32'h0);
        bus.mem_valid = 1'b0;
        tick();
        check("rdld_ready_idle", {31'h0, ld_ready}, 32'h1);
        check("rdld_lane_we", {28'h0, lane_we}, 32'h1);
        tick();
        check("rdld_count", {20'h0, ld_count}, 32'd1);
        ld_valid = 1'b0; ld_en = 1'b0;
        tick();

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            int r;
            if ($urandom_range(0, 99) < 3) ld_en = ~ld_en;
            ld_valid = 1'($urandom_range(0, 1));
            ld_data = 8'($urandom);
            r = $urandom_range(0, 9);
            bus.mem_valid = ($urandom_range(0, 99) < 70);
            if (r < 7)      bus.mem_addr = 32'($urandom_range(0, 63));
            else if (r < 9) bus.mem_addr = 32'($urandom_range(0, NB - 1));
            else            bus.mem_addr = $urandom | 32'h0000_1000;
            bus.mem_wdata = $urandom;
            bus.mem_wstrb = ($urandom_range(0, 1) == 1) ? 4'h0 : 4'($urandom_range(0, 15));
            tick();
        end
        cpu(1'b0, 32'h0, 32'h0, 4'h0);
        ld_en = 1'b0; ld_valid = 1'b0;
        tick(); tick(); tick();

        // Async reset while mem_ready is high, with a nonzero loader count
        ld_en = 1'b1; ld_valid = 1'b1;
        repeat (3) tick();
        ld_en = 1'b0; ld_valid = 1'b0;
        check("pre_rst_count", {20'h0, ld_count}, 32'd3);
        cpu(1'b1, 32'h8, 32'h0, 4'h0);
        tick(); tick();
        check("pre_rst_ready", {31'h0, bus.mem_ready}, 32'h1);
        #1 rsta = 1'b1;
        #1;
        check("async_rst_ready", {31'h0, bus.mem_ready}, 32'h0);
        check("async_rst_count", {20'h0, ld_count}, 32'h0);
        check("async_rst_ce", {28'h0, lane_ce}, 32'h0);
        tick();
        rsta = 1'b0; bus.mem_valid = 1'b0;
        tick();

        // Reset in the middle of RD: no acknowledge afterwards
        cpu(1'b1, 32'hC, 32'h0, 4'h0);
        tick();
        bus.mem_valid = 1'b0;
        #2 rsta = 1'b1;
        #1;
        check("rd_rst_ready", {31'h0, bus.mem_ready}, 32'h0);
        tick();
        rsta = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check("rd_rst_no_ack", {31'h0, bus.mem_ready}, 32'h0);
            tick();
        end

        // Reset in the accept cycle drops lane strobes immediately
        cpu(1'b1, 32'h0, 32'h0, 4'h0);
        #2;
        check("acc_ce", {28'h0, lane_ce}, 32'hF);
        rsta = 1'b1;
        #1;
        check("acc_rst_ce", {28'h0, lane_ce}, 32'h0);
        tick();
        rsta = 1'b0; bus.mem_valid = 1'b0;
        tick(); tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
